// File: rtl/green_mask_stream_ctrl.sv
// Streams an RGB frame one pixel per cycle and emits a "not green" mask bit per pixel.
// Thresholds are double-buffered: cfg writes go to shadow regs, which are latched on frame start.

module gm_chan_cmp #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] pix,
  input  logic [PIX_W-1:0] lo,
  input  logic [PIX_W-1:0] hi,
  output logic             in_rng
);
  assign in_rng = (pix >= lo) && (pix <= hi);
endmodule

module green_mask_stream_ctrl #(
  parameter int WIDTH  = 300,
  parameter int HEIGHT = 200,
  parameter int PIX_W  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  output logic                              busy,
  input  logic                              cfg_we,
  input  logic [3*PIX_W-1:0]                cfg_lower,
  input  logic [3*PIX_W-1:0]                cfg_upper,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [3*PIX_W-1:0]                s_pixel,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_mask,
  output logic [$clog2(HEIGHT)-1:0]         m_row,
  output logic [$clog2(WIDTH)-1:0]          m_col,
  output logic                              m_last,
  output logic                              frame_done,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] green_count
);
  localparam int RW  = $clog2(HEIGHT);
  localparam int CW  = $clog2(WIDTH);
  localparam int GW  = $clog2(WIDTH*HEIGHT+1);
  localparam int CHW = 3*PIX_W;
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT-1);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  logic [CHW-1:0] sh_lo, sh_hi, act_lo, act_hi;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [2:0]     ch_ok;
  logic           green, accept, at_end;

  for (genvar k = 0; k < 3; k++) begin : g_ch
    gm_chan_cmp #(.PIX_W(PIX_W)) u_cmp (
      .pix    (s_pixel[k*PIX_W +: PIX_W]),
      .lo     (act_lo[k*PIX_W +: PIX_W]),
      .hi     (act_hi[k*PIX_W +: PIX_W]),
      .in_rng (ch_ok[k])
    );
  end

  assign green   = &ch_ok;
  assign busy    = (state != IDLE);
  assign s_ready = (state == RUN) && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign at_end  = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sh_lo       <= '0;
      sh_hi       <= '1;
      act_lo      <= '0;
      act_hi      <= '1;
      row         <= '0;
      col         <= '0;
      m_valid     <= 1'b0;
      m_mask      <= 1'b0;
      m_row       <= '0;
      m_col       <= '0;
      m_last      <= 1'b0;
      frame_done  <= 1'b0;
      green_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (cfg_we) begin
        sh_lo <= cfg_lower;
        sh_hi <= cfg_upper;
      end
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state       <= RUN;
            row         <= '0;
            col         <= '0;
            green_count <= '0;
            // A cfg write in the start cycle bypasses the shadow regs.
            act_lo      <= cfg_we ? cfg_lower : sh_lo;
            act_hi      <= cfg_we ? cfg_upper : sh_hi;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            m_valid <= 1'b0;
          end else if (accept) begin
            m_valid <= 1'b1;
            m_mask  <= ~green;
            m_row   <= row;
            m_col   <= col;
            m_last  <= at_end;
            if (green) green_count <= green_count + GW'(1);
            if (col == COL_MAX) begin
              col <= '0;
              row <= at_end ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (at_end) state <= DRAIN;
          end else if (m_ready) begin
            m_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (abort) begin
            state   <= IDLE;
            m_valid <= 1'b0;
          end else if (m_valid && m_ready) begin
            m_valid    <= 1'b0;
            state      <= IDLE;
            frame_done <= m_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_green_mask_stream_ctrl.sv
// Directed bench for green_mask_stream_ctrl on a small frame; a frame-level model
// predicts the mask stream, counts and handshakes, checked every cycle.

module tb_green_mask_stream_ctrl;
  localparam int W  = 7;
  localparam int H  = 5;
  localparam int N  = W*H;
  localparam int PW = 8;

  logic clk = 0, rst = 1;
  logic start = 0, abort = 0, cfg_we = 0;
  logic [3*PW-1:0] cfg_lower = '0, cfg_upper = '0, s_pixel = '0;
  logic s_valid = 0, m_ready = 1;
  logic busy, s_ready, m_valid, m_mask, m_last, frame_done;
  logic [$clog2(H)-1:0] m_row;
  logic [$clog2(W)-1:0] m_col;
  logic [$clog2(N+1)-1:0] green_count;

  green_mask_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .cfg_we(cfg_we), .cfg_lower(cfg_lower), .cfg_upper(cfg_upper),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask), .m_row(m_row),
    .m_col(m_col), .m_last(m_last), .frame_done(frame_done),
    .green_count(green_count)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Frame-level model
  typedef struct { int mask; int row; int col; int last; } exp_t;
  exp_t q[$];
  exp_t e;
  logic [3*PW-1:0] sh_lo = '0, sh_hi = '1, ac_lo = '0, ac_hi = '1;
  int m_busy = 0, m_idx = 0, m_cnt = 0, m_fd = 0;
  int pat = 0, mr_mode = 0, cyc = 0;
  logic exp_sr, acc, hs;

  function automatic logic [3*PW-1:0] pix_fn(input int p, input int idx);
    case (p)
      0:       return (idx == 0) ? 24'h10A010 : 24'hFF00FF;
      1:       return 24'h112233;
      default: return (idx % 2 == 0) ? 24'h10A010 : 24'hFF00FF;
    endcase
  endfunction

  function automatic int is_green(input logic [3*PW-1:0] px, input logic [3*PW-1:0] lo,
                                  input logic [3*PW-1:0] hi);
    for (int k = 0; k < 3; k++)
      if (px[k*PW +: PW] < lo[k*PW +: PW] || px[k*PW +: PW] > hi[k*PW +: PW]) return 0;
    return 1;
  endfunction

  // Source / sink drivers
  always @(negedge clk) begin
    cyc++;
    s_valid = (cyc % 5 != 3);
    s_pixel = pix_fn(pat, m_idx);
    m_ready = (mr_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
  end

  // Compare process: checks registered outputs, then predicts the next edge.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      q.delete();
      sh_lo = '0; sh_hi = '1; ac_lo = '0; ac_hi = '1;
      m_busy = 0; m_idx = 0; m_cnt = 0; m_fd = 0;
    end else begin
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, m_fd);
      chk("green_count", green_count, m_cnt);
      chk("m_valid", m_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("m_mask", m_mask, q[0].mask);
        chk("m_row", m_row, q[0].row);
        chk("m_col", m_col, q[0].col);
        chk("m_last", m_last, q[0].last);
      end
      exp_sr = (m_busy != 0) && (m_idx < N) && (q.size() == 0 || m_ready);
      chk("s_ready", s_ready, exp_sr);
      acc = s_valid && exp_sr;
      hs  = (q.size() != 0) && m_ready;
      m_fd = 0;
      if (m_busy != 0 && abort) begin
        m_busy = 0;
        q.delete();
      end else if (m_busy == 0) begin
        if (start && !abort) begin
          m_busy = 1; m_idx = 0; m_cnt = 0;
          ac_lo = cfg_we ? cfg_lower : sh_lo;
          ac_hi = cfg_we ? cfg_upper : sh_hi;
        end
      end else begin
        if (hs) begin
          e = q.pop_front();
          if (e.last != 0) begin m_busy = 0; m_fd = 1; end
        end
        if (acc) begin
          e.mask = 1 - is_green(s_pixel, ac_lo, ac_hi);
          e.row  = m_idx / W;
          e.col  = m_idx % W;
          e.last = (m_idx == N-1);
          m_cnt += 1 - e.mask;
          m_idx++;
          q.push_back(e);
        end
      end
      if (cfg_we) begin sh_lo = cfg_lower; sh_hi = cfg_upper; end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_frame(input string nm);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    chk(nm, frame_done, 1);
  endtask

  task automatic wait_idx(input int n, input string nm);
    for (int i = 0; i < 1000 && m_idx < n; i++) @(negedge clk);
    chk(nm, m_idx, n);
  endtask

  initial begin
    #3;
    chk("rst_busy", busy, 0);       chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0); chk("rst_m_mask", m_mask, 0);
    chk("rst_m_last", m_last, 0);   chk("rst_frame_done", frame_done, 0);
    chk("rst_m_row", m_row, 0);     chk("rst_m_col", m_col, 0);
    chk("rst_green_count", green_count, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // T1: single green pixel at (0,0)
    @(negedge clk); cfg_we = 1; cfg_lower = 24'h008000; cfg_upper = 24'h40FF40;
    @(negedge clk); cfg_we = 0;
    pat = 0; mr_mode = 0;
    pulse_start();
    wait_frame("t1_done");
    chk("t1_gc", green_count, 1);

    // T2: backpressure, mid-frame cfg write must not take effect
    pat = 2; mr_mode = 1;
    pulse_start();
    wait_idx(10, "t2_idx");
    cfg_we = 1; cfg_lower = 24'h000000; cfg_upper = 24'h000000;
    @(negedge clk); cfg_we = 0;
    wait_frame("t2_done");
    chk("t2_gc", green_count, 18);

    // T3: new thresholds now active: nothing is green
    pulse_start();
    wait_frame("t3_done");
    chk("t3_gc", green_count, 0);

    // T4: cfg write in the start cycle goes straight to active
    mr_mode = 0; pat = 1;
    @(negedge clk);
    cfg_we = 1; start = 1; cfg_lower = 24'h112233; cfg_upper = 24'h112233;
    @(negedge clk); cfg_we = 0; start = 0;
    wait_frame("t4_done");
    chk("t4_gc", green_count, N);

    // T5: abort after 20 accepted pixels, then restart
    pulse_start();
    wait_idx(20, "t5_idx");
    abort = 1;
    @(negedge clk); abort = 0;
    chk("t5_busy", busy, 0);
    chk("t5_m_valid", m_valid, 0);
    chk("t5_gc", green_count, 20);
    repeat (5) @(negedge clk);
    chk("t5_gc_hold", green_count, 20);
    pulse_start();
    wait_frame("t5_done");
    chk("t5_gc_full", green_count, N);

    // T6: async reset mid-frame, then default thresholds pass everything
    pat = 0;
    pulse_start();
    wait_idx(10, "t6_idx");
    #3 rst = 1;
    #1;
    chk("t6_busy", busy, 0);       chk("t6_s_ready", s_ready, 0);
    chk("t6_m_valid", m_valid, 0); chk("t6_m_row", m_row, 0);
    chk("t6_m_col", m_col, 0);     chk("t6_gc", green_count, 0);
    chk("t6_m_last", m_last, 0);   chk("t6_m_mask", m_mask, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    pulse_start();
    wait_frame("t6_done");
    chk("t6_gc_full", green_count, N);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
